// File: rtl/prf_freelist_pkg.sv
// Core configuration defaults for the physical-register free list.
package prf_freelist_pkg;
    localparam int PRF_LG_N       = 6;
    localparam int PRF_N_RESERVED = 32;
endpackage

// File: rtl/prf_freelist_popcount.sv
// Population count of an N-bit vector, N = 1<<LG_N; result spans 0..N.
module popcount #(
    parameter int LG_N = 6
) (
    input  logic [(1<<LG_N)-1:0] bits,
    output logic [LG_N:0]        count
);
    localparam int N = 1 << LG_N;

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + (LG_N+1)'(bits[i]);
        end
    end
endmodule

// File: rtl/prf_freelist.sv
// Physical-register free list: one lowest-index allocation and up to two frees per cycle.
module prf_freelist
    import prf_freelist_pkg::*;
#(
    parameter int LG_N       = PRF_LG_N,
    parameter int N_RESERVED = PRF_N_RESERVED
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_req,
    output logic            alloc_gnt,
    output logic [LG_N-1:0] alloc_ptr,
    input  logic            free_valid0,
    input  logic [LG_N-1:0] free_ptr0,
    input  logic            free_valid1,
    input  logic [LG_N-1:0] free_ptr1,
    output logic [LG_N:0]   free_count,
    output logic            empty,
    output logic            double_free
);
    localparam int            N          = 1 << LG_N;
    localparam logic [N-1:0]  RESET_BITS = {N{1'b1}} << N_RESERVED;
    localparam logic [LG_N:0] RESET_CNT  = (LG_N+1)'(N - N_RESERVED);
    localparam logic          RESET_EMPTY = (N_RESERVED == N);

    logic [N-1:0]  free_bits;
    logic [N-1:0]  next_bits;
    logic [LG_N:0] next_count;
    logic          any_free;
    logic          dbl_now;

    // Scan from the top so the last hit is the lowest set bit.
    always_comb begin
        alloc_ptr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_bits[i]) alloc_ptr = LG_N'(i);
        end
    end

    assign any_free  = |free_bits;
    assign alloc_gnt = alloc_req & any_free;

    // Frees are ORed in after the grant clears its bit, so an illegal
    // free of the granted entry leaves it set.
    always_comb begin
        next_bits = free_bits;
        if (alloc_gnt)   next_bits[alloc_ptr] = 1'b0;
        if (free_valid0) next_bits[free_ptr0] = 1'b1;
        if (free_valid1) next_bits[free_ptr1] = 1'b1;
    end

    assign dbl_now = (free_valid0 & free_bits[free_ptr0])
                   | (free_valid1 & free_bits[free_ptr1])
                   | (free_valid0 & free_valid1 & (free_ptr0 == free_ptr1));

    popcount #(.LG_N(LG_N)) u_popcount (
        .bits  (next_bits),
        .count (next_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            free_bits   <= RESET_BITS;
            free_count  <= RESET_CNT;
            empty       <= RESET_EMPTY;
            double_free <= 1'b0;
        end else begin
            free_bits   <= next_bits;
            free_count  <= next_count;
            empty       <= (next_count == '0);
            double_free <= double_free | dbl_now;
        end
    end
endmodule
